// File: rtl/cache_controller_fsm.sv
// rtl/cache_controller_fsm.sv - direct-mapped write-back cache controller with saturating statistics
module cache_controller_fsm #(
  parameter int INDEX_W = 9,
  parameter int TAG_W   = 19,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_rden,
  input  logic               cpu_wren,
  input  logic [31:0]        cpu_addr,
  input  logic [31:0]        cpu_data_in,
  output logic               cpu_ready,
  output logic               cpu_done,
  output logic [31:0]        cpu_data_out,
  output logic [27:0]        cm_addr,
  output logic [127:0]       cm_data_in,
  output logic               cm_wren,
  output logic               cm_mark_dirty,
  input  logic [127:0]       cm_data_out,
  input  logic [TAG_W-1:0]   cm_tag_out,
  input  logic               cm_dirty,
  input  logic               cm_valid,
  output logic [31:0]        mem_addr,
  output logic [127:0]       mem_wdata,
  output logic               mem_wren,
  input  logic               mem_ready,
  output logic               mem_rd,
  input  logic [127:0]       mem_rdata,
  input  logic               mem_rdata_valid,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt,
  output logic [CNT_W-1:0]   wb_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE,
    WAIT_FILL,
    FILL
  } state_t;

  state_t state, next_state;

  // Request latched at acceptance; the CPU bus is free to change afterwards.
  logic [27:0]  req_line;
  logic [1:0]   req_word;
  logic [31:0]  req_data;
  logic         req_write;

  logic [27:0]  victim_addr;
  logic [127:0] victim_line;
  logic [127:0] fill_line;

  logic hit;
  logic accept;
  logic hit_inc, miss_inc, wb_inc;
  logic capture_victim, capture_fill;

  // Byte offset bits carry no meaning for a word port.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr[1:0];

  function automatic logic [31:0] word_sel(input logic [127:0] line, input logic [1:0] sel);
    return line[{sel, 5'b0} +: 32];
  endfunction

  function automatic logic [127:0] word_merge(input logic [127:0] line, input logic [31:0] word,
                                              input logic [1:0] sel);
    logic [127:0] merged;
    merged = line;
    merged[{sel, 5'b0} +: 32] = word;
    return merged;
  endfunction

  assign cpu_ready = (state == IDLE) && !reset;
  assign accept    = (state == IDLE) && (cpu_rden || cpu_wren);
  assign hit       = cm_valid && (cm_tag_out == req_line[27:INDEX_W]);
  assign cm_addr   = req_line;

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Request latch, victim capture and fill capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_line    <= '0;
      req_word    <= '0;
      req_data    <= '0;
      req_write   <= 1'b0;
      victim_addr <= '0;
      victim_line <= '0;
      fill_line   <= '0;
    end else begin
      if (accept) begin
        req_line  <= cpu_addr[31:4];
        req_word  <= cpu_addr[3:2];
        req_data  <= cpu_data_in;
        req_write <= cpu_wren;
      end
      if (capture_victim) begin
        victim_addr <= {cm_tag_out, req_line[INDEX_W-1:0]};
        victim_line <= cm_data_out;
      end
      if (capture_fill) fill_line <= mem_rdata;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (hit_inc  && hit_cnt  != '1) hit_cnt  <= hit_cnt  + 1'b1;
      if (miss_inc && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
      if (wb_inc   && wb_cnt   != '1) wb_cnt   <= wb_cnt   + 1'b1;
    end
  end

  // Next-state and output decode.
  always_comb begin
    next_state     = state;
    cpu_done       = 1'b0;
    cpu_data_out   = '0;
    cm_data_in     = '0;
    cm_wren        = 1'b0;
    cm_mark_dirty  = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_wren       = 1'b0;
    mem_rd         = 1'b0;
    hit_inc        = 1'b0;
    miss_inc       = 1'b0;
    wb_inc         = 1'b0;
    capture_victim = 1'b0;
    capture_fill   = 1'b0;

    case (state)
      IDLE: begin
        if (accept) next_state = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          hit_inc    = 1'b1;
          cpu_done   = 1'b1;
          next_state = IDLE;
          if (req_write) begin
            cm_wren       = 1'b1;
            cm_mark_dirty = 1'b1;
            cm_data_in    = word_merge(cm_data_out, req_data, req_word);
          end else begin
            cpu_data_out = word_sel(cm_data_out, req_word);
          end
        end else begin
          miss_inc = 1'b1;
          if (cm_valid && cm_dirty) begin
            capture_victim = 1'b1;
            wb_inc         = 1'b1;
            next_state     = WRITEBACK;
          end else begin
            next_state = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        mem_wren  = 1'b1;
        mem_addr  = {victim_addr, 4'b0};
        mem_wdata = victim_line;
        if (mem_ready) next_state = ALLOCATE;
      end
      ALLOCATE: begin
        mem_rd     = 1'b1;
        mem_addr   = {req_line, 4'b0};
        next_state = WAIT_FILL;
      end
      WAIT_FILL: begin
        if (mem_rdata_valid) begin
          capture_fill = 1'b1;
          next_state   = FILL;
        end
      end
      FILL: begin
        cm_wren    = 1'b1;
        cpu_done   = 1'b1;
        next_state = IDLE;
        if (req_write) begin
          cm_mark_dirty = 1'b1;
          cm_data_in    = word_merge(fill_line, req_data, req_word);
        end else begin
          cm_data_in   = fill_line;
          cpu_data_out = word_sel(fill_line, req_word);
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_controller_fsm.sv
// tb/tb_cache_controller_fsm.sv - scoreboard bench for cache_controller_fsm
module tb_cache_controller_fsm;

  localparam int INDEX_W = 9;
  localparam int TAG_W   = 19;
  localparam int CNT_W   = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cpu_rden = 1'b0;
  logic               cpu_wren = 1'b0;
  logic [31:0]        cpu_addr = '0;
  logic [31:0]        cpu_data_in = '0;
  logic               cpu_ready;
  logic               cpu_done;
  logic [31:0]        cpu_data_out;
  logic [27:0]        cm_addr;
  logic [127:0]       cm_data_in;
  logic               cm_wren;
  logic               cm_mark_dirty;
  logic [127:0]       cm_data_out;
  logic [TAG_W-1:0]   cm_tag_out;
  logic               cm_dirty;
  logic               cm_valid;
  logic [31:0]        mem_addr;
  logic [127:0]       mem_wdata;
  logic               mem_wren;
  logic               mem_ready = 1'b0;
  logic               mem_rd;
  logic [127:0]       mem_rdata = '0;
  logic               mem_rdata_valid = 1'b0;
  logic [CNT_W-1:0]   hit_cnt, miss_cnt, wb_cnt;

  cache_controller_fsm #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cpu_rden(cpu_rden), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_data_out(cpu_data_out),
    .cm_addr(cm_addr), .cm_data_in(cm_data_in), .cm_wren(cm_wren), .cm_mark_dirty(cm_mark_dirty),
    .cm_data_out(cm_data_out), .cm_tag_out(cm_tag_out), .cm_dirty(cm_dirty), .cm_valid(cm_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- line array (environment) ----------------
  logic [127:0] arr_data  [512];
  logic [18:0]  arr_tag   [512];
  logic         arr_valid [512];
  logic         arr_dirty [512];

  initial begin
    for (int i = 0; i < 512; i++) begin
      arr_data[i] = '0; arr_tag[i] = '0; arr_valid[i] = 1'b0; arr_dirty[i] = 1'b0;
    end
  end

  assign cm_data_out = arr_data[cm_addr[8:0]];
  assign cm_tag_out  = arr_tag[cm_addr[8:0]];
  assign cm_valid    = arr_valid[cm_addr[8:0]];
  assign cm_dirty    = arr_dirty[cm_addr[8:0]];

  always @(posedge clk) begin
    if (cm_wren) begin
      arr_data[cm_addr[8:0]]  <= cm_data_in;
      arr_tag[cm_addr[8:0]]   <= cm_addr[27:9];
      arr_valid[cm_addr[8:0]] <= 1'b1;
      arr_dirty[cm_addr[8:0]] <= cm_mark_dirty;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] init_word(input logic [29:0] wa);
    return ({2'b0, wa} * 32'h9E3779B1) ^ 32'hC0FFEE00;
  endfunction

  logic [31:0]  flat    [logic [29:0]];
  logic [127:0] backing [logic [27:0]];

  function automatic logic [31:0] rd_flat(input logic [29:0] wa);
    return flat.exists(wa) ? flat[wa] : init_word(wa);
  endfunction

  function automatic logic [127:0] line_of(input logic [27:0] la);
    return {rd_flat({la, 2'd3}), rd_flat({la, 2'd2}), rd_flat({la, 2'd1}), rd_flat({la, 2'd0})};
  endfunction

  function automatic logic [127:0] backing_line(input logic [27:0] la);
    if (backing.exists(la)) return backing[la];
    return {init_word({la, 2'd3}), init_word({la, 2'd2}), init_word({la, 2'd1}), init_word({la, 2'd0})};
  endfunction

  function automatic logic [1:0] sat(input int x);
    return (x > 3) ? 2'd3 : x[1:0];
  endfunction

  typedef struct { bit rd; logic [31:0] data; int lat; logic [1:0] h, m, w; } exp_t;
  typedef struct { logic [27:0] addr; logic [127:0] line; logic dirty; } cm_t;
  typedef struct { logic [31:0] addr; logic [127:0] line; int delay; } wb_t;
  typedef struct { logic [31:0] addr; int cas; } rd_t;

  exp_t exp_q[$];
  int   acc_q[$];
  cm_t  cm_q[$];
  wb_t  wb_q[$];
  rd_t  rd_q[$];

  bit          m_valid [512];
  bit          m_dirty [512];
  logic [18:0] m_tag   [512];
  int m_hits = 0, m_miss = 0, m_wb = 0;

  // Latency convention: cas counts the mem_rd cycle as the first cycle of the fill wait.
  task automatic predict(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input int cas, input int wbd);
    logic [27:0] la;
    logic [8:0]  idx;
    logic [18:0] tag;
    bit          was_hit;
    exp_t e; cm_t c; wb_t w; rd_t r;
    la = addr[31:4]; idx = la[8:0]; tag = la[27:9];
    was_hit = m_valid[idx] && (m_tag[idx] == tag);
    if (was_hit) begin
      m_hits++;
      e.lat = 1;
      if (wr) m_dirty[idx] = 1'b1;
    end else begin
      m_miss++;
      e.lat = 2 + cas;
      if (m_valid[idx] && m_dirty[idx]) begin
        m_wb++;
        w.addr = {m_tag[idx], idx, 4'b0};
        w.line = line_of({m_tag[idx], idx});
        w.delay = wbd;
        wb_q.push_back(w);
        e.lat += wbd + 1;
      end
      r.addr = {la, 4'b0};
      r.cas = cas;
      rd_q.push_back(r);
      m_valid[idx] = 1'b1;
      m_tag[idx] = tag;
      m_dirty[idx] = wr;
    end
    if (wr) flat[addr[31:2]] = data;
    if (wr || !was_hit) begin
      c.addr = la; c.line = line_of(la); c.dirty = wr;
      cm_q.push_back(c);
    end
    e.rd = !wr;
    e.data = rd_flat(addr[31:2]);
    e.h = sat(m_hits); e.m = sat(m_miss); e.w = sat(m_wb);
    exp_q.push_back(e);
  endtask

  // ---------------- memory responder ----------------
  int wb_seen = 0;
  int fill_cd = 0;
  logic [127:0] fill_buf = '0;

  always @(negedge clk) begin
    wb_t w; rd_t r;
    if (mem_wren) begin
      wb_seen++;
      if (wb_q.size() == 0) begin
        chk("unexpected_mem_wren", {127'b0, mem_wren}, 128'd0);
        mem_ready = 1'b1;
        wb_seen = 0;
      end else if (wb_seen > wb_q[0].delay) begin
        w = wb_q.pop_front();
        chk("wb_addr", {96'b0, mem_addr}, {96'b0, w.addr});
        chk("wb_data", mem_wdata, w.line);
        backing[mem_addr[31:4]] = mem_wdata;
        mem_ready = 1'b1;
        wb_seen = 0;
      end else begin
        mem_ready = 1'b0;
      end
    end else begin
      mem_ready = 1'b0;
      wb_seen = 0;
    end

    mem_rdata_valid = 1'b0;
    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    if (fill_cd > 0) begin
      fill_cd--;
      if (fill_cd == 0) begin
        mem_rdata_valid = 1'b1;
        mem_rdata = fill_buf;
      end
    end
    if (mem_rd) begin
      if (rd_q.size() == 0) begin
        chk("unexpected_mem_rd", {127'b0, mem_rd}, 128'd0);
        fill_cd = 2;
      end else begin
        r = rd_q.pop_front();
        chk("rd_addr", {96'b0, mem_addr}, {96'b0, r.addr});
        fill_cd = r.cas - 1;
      end
      fill_buf = backing_line(mem_addr[31:4]);
    end
  end

  // ---------------- scoreboard monitor ----------------
  bit   cnt_pending = 0;
  exp_t cnt_exp;

  always @(negedge clk) begin
    exp_t e; cm_t c; int a;
    if (reset) begin
      cnt_pending = 0;
    end else begin
      if (cnt_pending) begin
        chk("hit_cnt",  {126'b0, hit_cnt},  {126'b0, cnt_exp.h});
        chk("miss_cnt", {126'b0, miss_cnt}, {126'b0, cnt_exp.m});
        chk("wb_cnt",   {126'b0, wb_cnt},   {126'b0, cnt_exp.w});
        cnt_pending = 0;
      end
      if (cpu_done) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          chk("unexpected_done", {127'b0, cpu_done}, 128'd0);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("latency", 128'(cyc - a), 128'(e.lat));
          if (e.rd) chk("rdata", {96'b0, cpu_data_out}, {96'b0, e.data});
          cnt_exp = e;
          cnt_pending = 1;
        end
      end
      if (cm_wren) begin
        if (cm_q.size() == 0) begin
          chk("unexpected_cm_wren", {127'b0, cm_wren}, 128'd0);
        end else begin
          c = cm_q.pop_front();
          chk("cm_addr", {100'b0, cm_addr}, {100'b0, c.addr});
          chk("cm_data", cm_data_in, c.line);
          chk("cm_dirty", {127'b0, cm_mark_dirty}, {127'b0, c.dirty});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input bit wr, input bit both, input logic [31:0] addr,
                       input logic [31:0] data, input int cas, input int wbd);
    int n;
    predict(wr, addr, data, cas, wbd);
    cpu_wren = wr;
    cpu_rden = wr ? both : 1'b1;
    cpu_addr = addr;
    cpu_data_in = data;
    n = 0;
    while (!cpu_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cpu_ready) chk("accept_timeout", {127'b0, cpu_ready}, 128'd1);
    acc_q.push_back(cyc);
    @(negedge clk);
    cpu_rden = 1'b0;
    cpu_wren = 1'b0;
    cpu_addr = $urandom;
    cpu_data_in = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cm_q.size() != 0 || wb_q.size() != 0 || rd_q.size() != 0 || !cpu_ready)
           && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 128'(n), 128'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_ready", {127'b0, cpu_ready}, 128'd0);
    chk("rst_done",  {127'b0, cpu_done}, 128'd0);
    chk("rst_strobes", {125'b0, cm_wren, mem_wren, mem_rd}, 128'd0);
    chk("rst_counters", {122'b0, hit_cnt, miss_cnt, wb_cnt}, 128'd0);
  endtask

  task automatic do_reset();
    drain();
    reset = 1'b1;
    m_hits = 0; m_miss = 0; m_wb = 0;
    @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rd_t r;
    logic [18:0] tg;
    logic [8:0]  ix;
    bit wr;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {127'b0, cpu_ready}, 128'd1);

    issue(1'b0, 1'b0, 32'h0000_1004, 32'h0, 5, 0);
    issue(1'b0, 1'b0, 32'h0000_1008, 32'h0, 2, 0);
    issue(1'b1, 1'b0, 32'h0000_100C, 32'hDEADBEEF, 2, 0);
    issue(1'b0, 1'b0, 32'h0020_1000, 32'h0, 3, 3);
    issue(1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678, 4, 0);
    repeat (4) issue(1'b0, 1'b0, 32'h0000_2004, 32'h0, 2, 0);
    drain();

    // Reset while waiting for a fill; the fill data then arrives after reset is released.
    r.addr = 32'h0000_1F00;
    r.cas = 8;
    rd_q.push_back(r);
    cpu_rden = 1'b1;
    cpu_addr = 32'h0000_1F00;
    @(negedge clk);
    cpu_rden = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    m_hits = 0; m_miss = 0; m_wb = 0;
    @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_counters", {122'b0, hit_cnt, miss_cnt, wb_cnt}, 128'd0);
    chk("abort_ready", {127'b0, cpu_ready}, 128'd1);
    chk("abort_rd_seen", 128'(rd_q.size()), 128'd0);

    for (int k = 0; k < 8; k++) begin
      do_reset();
      for (int i = 0; i < 12; i++) begin
        tg = 19'($urandom_range(0, 3));
        ix = 9'($urandom_range(0, 7));
        wr = 1'($urandom_range(0, 1));
        issue(wr, 1'($urandom_range(0, 1)), {tg, ix, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))},
              $urandom, $urandom_range(2, 6), $urandom_range(0, 3));
      end
    end
    drain();

    chk("exp_q_empty", 128'(exp_q.size()), 128'd0);
    chk("cm_q_empty",  128'(cm_q.size()),  128'd0);
    chk("wb_q_empty",  128'(wb_q.size()),  128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
